vec_lane_sequencer: RTL and testbench
=====================================

# vec_lane_sequencer

Multi-cycle controller that runs a vector ALU operation lane by lane through the single shared scalar ALU, then commits all lanes to the vector register file in one write. It sits between the decoder and the datapath:
- it drives the lane-select muxes that pick operand words for the ALU;
- it captures each lane result in a lane buffer;
- it stalls the PC register while the operation is in flight.

## Interface
Parameters:
- LANES, 5, number of vector lanes (words per vector register).
- DW, 32, lane data width.
- IDX_W, 3, lane index width; must satisfy 2**IDX_W >= LANES.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  decoder request to issue a vector operation.
- op_in  in  3  ALU operation code for the vector operation.
- vd_in  in  4  destination vector register address (Instr[15:12]).
- flush  in  1  synchronous abort; the operation is discarded and nothing is written.
- alu_result  in  DW  shared ALU output for the currently selected lane.
- lane_mask  in  LANES  per-lane enable; present only with VLSEQ_MASK_EN.
- lane_sel  out  IDX_W  lane index driving the operand muxes.
- alu_op  out  3  operation code held for the whole operation.
- vec_we  out  1  vector register file write enable; single-cycle pulse.
- vec_wa  out  4  vector write address.
- vec_wdata  out  LANES*DW  packed write data; lane i occupies bits [i*DW +: DW].
- busy  out  1  high while the sequencer is not IDLE.
- stall  out  1  hold for the PC register and scalar RegWrite.
- done  out  1  one-cycle completion pulse, coincident with vec_we.

## Operation
- States: IDLE, RUN, WB.
- IDLE, start=1: latch op_in and vd_in (and lane_mask when enabled); lane_sel <= 0; go to RUN.
- RUN, every cycle:
  - buf[lane_sel] <= alu_result, or 0 if that lane is masked off;
  - if lane_sel == LANES-1, go to WB; otherwise lane_sel increments.
- WB: vec_we=1, vec_wa=latched vd, vec_wdata=buf, done=1; next state IDLE and lane_sel <= 0.
- stall = (IDLE & start) | RUN. It is deasserted in WB, so the PC advances on the WB edge.
- start in RUN or WB is ignored; there is no queue. The decoder holds start until it sees done.
- flush in RUN or WB: go to IDLE at the next edge; vec_we is forced 0 in that cycle; the lane buffer is left as is.
- flush and start together in IDLE: flush wins and the operation is not accepted.
- alu_op is held stable from the accept edge through WB. Outputs are registered, except stall and vec_we/done, which are decoded from state.
- Width rule: lane_sel never exceeds LANES-1. No wrap beyond LANES.

## Timing
- Reset values:
  - state IDLE;
  - lane_sel, alu_op, vec_wa, vec_wdata all 0;
  - vec_we, busy, stall (when start=0) and done all 0.
- Start accepted at edge k. RUN occupies cycles k+1..k+LANES and captures lane i at edge k+1+i. WB is cycle k+LANES+1.
- Latency from start to vec_we is LANES+1 cycles (6 with defaults). Back-to-back issue is possible from the cycle after WB.
- alu_result for lane i must be valid, combinationally, in the cycle in which lane_sel=i.
- Reset asserted mid-operation: immediate return to IDLE, with no write and no done.

## Configuration
- VLSEQ_MASK_EN defined:
  - the lane_mask port exists and is sampled at accept;
  - masked-off lanes write 0 and still consume their RUN cycle, so latency is fixed.
- VLSEQ_MASK_EN undefined: the port is absent and all lanes are active.

## Structure
- Shared package vlseq_pkg: state enum (IDLE, RUN, WB), LANES, DW, IDX_W defaults, ALU op-code constants.
- One sub-module, vlseq_lane_buf: LANES×DW register array with an indexed write port and a packed read-out.

## Test plan
- Reset, then start with op=ADD, vd=3, ALU returning lane*0x10 -> vec_we pulse 6 cycles after accept, vec_wa=3, vec_wdata lanes = 0,0x10,0x20,0x30,0x40, done coincident.
- start held high through the operation -> exactly one write. A second accept occurs in the cycle after WB; stall is high for 6 of every 7 cycles.
- flush asserted at lane 2 -> no vec_we, no done, state IDLE on the next edge, stall drops.
- reset driven low at lane 3 -> all outputs 0 immediately. No write occurs after reset is released.
- VLSEQ_MASK_EN, mask=5'b10101, ALU=0xFFFFFFFF -> lanes 0, 2, 4 = 0xFFFFFFFF; lanes 1, 3 = 0; latency still 6.
- start with flush in the same IDLE cycle -> not accepted, busy stays 0.

Source files
------------

// File: rtl/vec_lane_sequencer_pkg.sv
// Shared types and defaults for the vector lane sequencer.
// Exposes the FSM state enum, default sizing and the ALU op-code set.
package vlseq_pkg;

  localparam int LANES_DEF = 5;
  localparam int DW_DEF    = 32;
  localparam int IDX_W_DEF = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WB   = 2'd2
  } state_e;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SLL = 3'd5;
  localparam logic [2:0] OP_SRL = 3'd6;
  localparam logic [2:0] OP_SLT = 3'd7;

endpackage

// File: rtl/vec_lane_sequencer_if.sv
// Decoder/datapath bundle for the vector lane sequencer.
// master: decoder+datapath side; slave: the sequencer. lane_mask only with VLSEQ_MASK_EN.
interface vlseq_if #(
  parameter int LANES = vlseq_pkg::LANES_DEF,
  parameter int DW    = vlseq_pkg::DW_DEF,
  parameter int IDX_W = vlseq_pkg::IDX_W_DEF
);

  logic                  start;
  logic [2:0]            op_in;
  logic [3:0]            vd_in;
  logic                  flush;
  logic [DW-1:0]         alu_result;
`ifdef VLSEQ_MASK_EN
  logic [LANES-1:0]      lane_mask;
`endif
  logic [IDX_W-1:0]      lane_sel;
  logic [2:0]            alu_op;
  logic                  vec_we;
  logic [3:0]            vec_wa;
  logic [LANES*DW-1:0]   vec_wdata;
  logic                  busy;
  logic                  stall;
  logic                  done;

  modport master (
`ifdef VLSEQ_MASK_EN
    output lane_mask,
`endif
    output start, op_in, vd_in, flush, alu_result,
    input  lane_sel, alu_op, vec_we, vec_wa,
    input  vec_wdata, busy, stall, done
  );

  modport slave (
`ifdef VLSEQ_MASK_EN
    input  lane_mask,
`endif
    input  start, op_in, vd_in, flush, alu_result,
    output lane_sel, alu_op, vec_we, vec_wa,
    output vec_wdata, busy, stall, done
  );

endinterface

// File: rtl/vec_lane_sequencer_lane_buf.sv
// Lane result buffer: LANES x DW registers, one indexed write port.
// Ports: clk, rst_n, we, idx, wdata in; rdata out (lane i at [i*DW +: DW]).
module vlseq_lane_buf #(
  parameter int LANES = 5,
  parameter int DW    = 32,
  parameter int IDX_W = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic [IDX_W-1:0]    idx,
  input  logic [DW-1:0]       wdata,
  output logic [LANES*DW-1:0] rdata
);

  logic [DW-1:0] mem [LANES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LANES; i++)
        mem[i] <= '0;
    end else if (we) begin
      for (int i = 0; i < LANES; i++)
        if (idx == IDX_W'(i))
          mem[i] <= wdata;
    end
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < LANES; i++)
      rdata[i*DW +: DW] = mem[i];
  end

endmodule

// File: rtl/vec_lane_sequencer.sv
// Runs one vector op lane by lane through the scalar ALU, then commits all lanes.
// Ports: clk, reset (async, active-low), bus (vlseq_if.slave). Option: VLSEQ_MASK_EN.
module vec_lane_sequencer
  import vlseq_pkg::*;
#(
  parameter int LANES = LANES_DEF,
  parameter int DW    = DW_DEF,
  parameter int IDX_W = IDX_W_DEF
) (
  input  logic   clk,
  input  logic   reset,
  vlseq_if.slave bus
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(LANES - 1);

  state_e             state;
  logic [IDX_W-1:0]   lane_sel;
  logic [2:0]         alu_op;
  logic [3:0]         vd;
  logic [LANES-1:0]   mask_q;
  logic [LANES*DW-1:0] buf_q;

  logic is_idle;
  logic is_run;
  logic is_wb;
  logic accept;
  logic buf_we;
  logic [DW-1:0] lane_d;

  assign is_idle = (state == IDLE);
  assign is_run  = (state == RUN);
  assign is_wb   = (state == WB);

  // flush beats start in IDLE
  assign accept  = is_idle & bus.start & ~bus.flush;
  assign buf_we  = is_run & ~bus.flush;
  assign lane_d  = mask_q[lane_sel] ? bus.alu_result : '0;

`ifdef VLSEQ_MASK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      mask_q <= '0;
    else if (accept)
      mask_q <= bus.lane_mask;
  end
`else
  assign mask_q = '1;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      lane_sel <= '0;
      alu_op   <= '0;
      vd       <= '0;
    end else begin
      unique case (1'b1)
        is_idle: begin
          if (accept) begin
            state    <= RUN;
            lane_sel <= '0;
            alu_op   <= bus.op_in;
            vd       <= bus.vd_in;
          end
        end
        is_run: begin
          if (bus.flush) begin
            state    <= IDLE;
            lane_sel <= '0;
          end else if (lane_sel == LAST) begin
            state    <= WB;
          end else begin
            lane_sel <= lane_sel + IDX_W'(1);
          end
        end
        is_wb: begin
          state    <= IDLE;
          lane_sel <= '0;
        end
        default: begin
          state    <= IDLE;
          lane_sel <= '0;
        end
      endcase
    end
  end

  vlseq_lane_buf #(
    .LANES (LANES),
    .DW    (DW),
    .IDX_W (IDX_W)
  ) u_buf (
    .clk   (clk),
    .rst_n (reset),
    .we    (buf_we),
    .idx   (lane_sel),
    .wdata (lane_d),
    .rdata (buf_q)
  );

  assign bus.lane_sel  = lane_sel;
  assign bus.alu_op    = alu_op;
  assign bus.vec_wa    = vd;
  assign bus.vec_wdata = buf_q;
  assign bus.busy      = ~is_idle;
  // PC may advance on the WB edge
  assign bus.stall     = (is_idle & bus.start) | is_run;
  assign bus.vec_we    = is_wb & ~bus.flush;
  assign bus.done      = is_wb & ~bus.flush;

endmodule

// File: tb/tb_vec_lane_sequencer.sv
// Self-checking bench for vec_lane_sequencer: directed cases plus random traffic.
// A phase-counter reference model is compared against the DUT every cycle.
module tb_vec_lane_sequencer;
  import vlseq_pkg::*;

  localparam int LANES = 5;
  localparam int DW    = 32;
  localparam int IDX_W = 3;
  localparam int VW    = LANES * DW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vlseq_if #(.LANES(LANES), .DW(DW), .IDX_W(IDX_W)) bus ();

  vec_lane_sequencer #(
    .LANES (LANES),
    .DW    (DW),
    .IDX_W (IDX_W)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  logic [DW-1:0]    alu_tab [LANES];
  logic [LANES-1:0] mask_drv;

`ifdef VLSEQ_MASK_EN
  assign bus.lane_mask = mask_drv;
`endif

  always_comb begin
    bus.alu_result = '0;
    if (int'(bus.lane_sel) < LANES)
      bus.alu_result = alu_tab[bus.lane_sel];
  end

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  task automatic chk(string name, logic [VW-1:0] act, logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: p=0 idle, p=1..LANES working on lane p-1, p=LANES+1 write-back
  int               p;
  logic [2:0]       m_op;
  logic [3:0]       m_vd;
  logic [LANES-1:0] m_mask;
  logic [DW-1:0]    m_buf [LANES];

  function automatic logic [VW-1:0] pack_model();
    logic [VW-1:0] v;
    v = '0;
    for (int i = 0; i < LANES; i++)
      v[i*DW +: DW] = m_buf[i];
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p = 0; m_op = '0; m_vd = '0; m_mask = '0;
      for (int i = 0; i < LANES; i++) m_buf[i] = '0;
    end else if (p == 0) begin
      if (bus.start && !bus.flush) begin
        p = 1;
        m_op = bus.op_in;
        m_vd = bus.vd_in;
`ifdef VLSEQ_MASK_EN
        m_mask = mask_drv;
`else
        m_mask = '1;
`endif
      end
    end else if (bus.flush) begin
      p = 0;
    end else if (p <= LANES) begin
      m_buf[p-1] = m_mask[p-1] ? alu_tab[p-1] : '0;
      p = p + 1;
    end else begin
      p = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      int  e_ls;
      bit  e_we, e_stall;
      e_ls    = (p >= 1 && p <= LANES) ? p - 1 : ((p == LANES + 1) ? LANES - 1 : 0);
      e_we    = (p == LANES + 1) && !bus.flush;
      e_stall = (p == 0 && bus.start) || (p >= 1 && p <= LANES);
      chk("lane_sel", VW'(bus.lane_sel), VW'(e_ls));
      chk("alu_op", VW'(bus.alu_op), VW'(m_op));
      chk("vec_wa", VW'(bus.vec_wa), VW'(m_vd));
      chk("vec_wdata", bus.vec_wdata, pack_model());
      chk("busy", VW'(bus.busy), VW'(p != 0));
      chk("stall", VW'(bus.stall), VW'(e_stall));
      chk("vec_we", VW'(bus.vec_we), VW'(e_we));
      chk("done", VW'(bus.done), VW'(e_we));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_lane_sel"}, VW'(bus.lane_sel), '0);
    chk({tag, "_alu_op"}, VW'(bus.alu_op), '0);
    chk({tag, "_vec_wa"}, VW'(bus.vec_wa), '0);
    chk({tag, "_vec_wdata"}, bus.vec_wdata, '0);
    chk({tag, "_vec_we"}, VW'(bus.vec_we), '0);
    chk({tag, "_busy"}, VW'(bus.busy), '0);
    chk({tag, "_stall"}, VW'(bus.stall), '0);
    chk({tag, "_done"}, VW'(bus.done), '0);
  endtask

  // Issue one op, drop start after accept, and measure cycles to vec_we.
  task automatic run_op(string tag, logic [3:0] vd, logic [VW-1:0] exp_data);
    int lat;
    lat = 0;
    bus.op_in = OP_ADD;
    bus.vd_in = vd;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (bus.vec_we) begin
        lat = i;
        chk({tag, "_wa"}, VW'(bus.vec_wa), VW'(vd));
        chk({tag, "_wdata"}, bus.vec_wdata, exp_data);
        chk({tag, "_model_wdata"}, pack_model(), exp_data);
        chk({tag, "_done"}, VW'(bus.done), VW'(1));
        break;
      end
    end
    chk({tag, "_latency"}, VW'(lat), VW'(LANES + 1));
    tick();
  endtask

  initial begin
    int n_stall, n_we;
    logic [VW-1:0] exp;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.op_in = '0;
    bus.vd_in = '0;
    mask_drv  = '1;
    for (int i = 0; i < LANES; i++) alu_tab[i] = '0;

    #12;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1;
    tick();

    // basic op: lane i returns i*0x10
    for (int i = 0; i < LANES; i++) alu_tab[i] = DW'(i * 16);
    exp = 160'h00000040_00000030_00000020_00000010_00000000;
    run_op("basic", 4'd3, exp);

    // start held: one write per 7 cycles, stall 6 of 7
    n_stall = 0;
    n_we = 0;
    bus.vd_in = 4'd5;
    bus.start = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      n_stall += int'(bus.stall);
      n_we += int'(bus.vec_we);
    end
    #1 bus.start = 1'b0;
    chk("held_stall_cnt", VW'(n_stall), VW'(12));
    chk("held_we_cnt", VW'(n_we), VW'(2));
    tick();
    tick();

    // flush during lane 2
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    bus.flush = 1'b1;
    @(negedge clk);
    chk("flush_lane", VW'(bus.lane_sel), VW'(2));
    chk("flush_we", VW'(bus.vec_we), '0);
    tick();
    bus.flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", VW'(bus.busy), '0);
    chk("flush_stall", VW'(bus.stall), '0);
    n_we = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_we += int'(bus.vec_we) + int'(bus.done);
    end
    chk("flush_no_write", VW'(n_we), '0);
    tick();

    // reset during lane 3
    bus.vd_in = 4'd9;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1 chk_zero("midreset");
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    n_we = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_we += int'(bus.vec_we) + int'(bus.done) + int'(bus.busy);
    end
    chk("post_reset_idle", VW'(n_we), '0);
    tick();

    // start with flush in IDLE is refused
    bus.start = 1'b1;
    bus.flush = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.flush = 1'b0;
    @(negedge clk);
    chk("startflush_busy", VW'(bus.busy), '0);
    tick();

`ifdef VLSEQ_MASK_EN
    for (int i = 0; i < LANES; i++) alu_tab[i] = '1;
    mask_drv = 5'b10101;
    exp = 160'hFFFFFFFF_00000000_FFFFFFFF_00000000_FFFFFFFF;
    run_op("mask", 4'd7, exp);
    mask_drv = '1;
`endif

    // random traffic against the model
    for (int c = 0; c < 400; c++) begin
      tick();
      if (p == 0)
        for (int i = 0; i < LANES; i++) alu_tab[i] = $urandom;
      bus.start = 1'($urandom_range(0, 1));
      bus.flush = ($urandom_range(0, 11) == 0);
      bus.op_in = 3'($urandom);
      bus.vd_in = 4'($urandom);
      mask_drv  = LANES'($urandom);
    end
    bus.start = 1'b0;
    bus.flush = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("final_idle", VW'(bus.busy), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
